// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// ratio and the parity rule that both uart_tx and uart_rx agree on.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Expected parity bit for a data word. Callers zero-extend narrower words;
  // zero padding does not change the XOR reduction.
  // even_odd = 1 -> ^data, even_odd = 0 -> ~^data.
  function automatic logic expected_parity(input logic [31:0] data,
                                           input logic        even_odd);
    return even_odd ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pad. Both flops reset to 1
// so the receiver sees an idle line straight out of reset.
module uart_rx_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_data,
  output logic o_data
);

  logic meta;

  // Shift the raw line through two flops every clock.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta   <= 1'b1;
      o_data <= 1'b1;
    end else begin
      meta   <= i_data;
      o_data <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit detection, LSB-first data capture,
// optional parity check and one or more stop bits with framing check.
// All activity except the synchroniser advances only on i_valid ticks.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int N_DATA          = 8,
  parameter int LOG2_N_DATA     = 4,
  parameter int PARITY_CHECK    = 0,
  parameter int EVEN_ODD_PARITY = 1,
  parameter int M_STOP          = 1,
  parameter int LOG2_M_STOP     = 1,
  parameter int OVERSAMPLE      = DEFAULT_OVERSAMPLE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_data,
  input  logic               i_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_error,
  output logic               o_frame_error
);

  localparam int NB_TICK = $clog2(OVERSAMPLE);
  localparam logic [NB_TICK-1:0]     TICK_MID_START = NB_TICK'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_TICK-1:0]     TICK_MID_BIT   = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [LOG2_N_DATA-1:0] LAST_DATA      = LOG2_N_DATA'(N_DATA - 1);
  localparam logic [LOG2_M_STOP-1:0] LAST_STOP      = LOG2_M_STOP'(M_STOP - 1);
  localparam bit                     HAS_PARITY     = (PARITY_CHECK != 0);
  localparam bit                     PARITY_RULE    = (EVEN_ODD_PARITY != 0);

  logic                   rx;
  state_t                 state;
  state_t                 state_next;
  logic [NB_TICK-1:0]     tick;
  logic [LOG2_N_DATA-1:0] data_cnt;
  logic [LOG2_M_STOP-1:0] stop_cnt;
  logic [N_DATA-1:0]      shreg;
  logic                   parity_err;
  logic                   frame_acc;
  logic                   mid_bit;
  logic                   frame_done;

  uart_rx_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (i_data),
    .o_data  (rx)
  );

  // Next-state decode; START re-checks the line at mid start bit to reject
  // glitches, the other states act once per bit at the mid-bit tick.
  always_comb begin
    state_next = state;
    mid_bit    = i_valid && (tick == TICK_MID_BIT);
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (i_valid && !rx) state_next = ST_START;
      ST_START:  if (i_valid && (tick == TICK_MID_START)) state_next = rx ? ST_IDLE : ST_DATA;
      ST_DATA:   if (mid_bit && (data_cnt == LAST_DATA)) state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY: if (mid_bit) state_next = ST_STOP;
      ST_STOP: begin
        if (mid_bit && (stop_cnt == LAST_STOP)) begin
          state_next = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, tick/bit counters and per-frame capture; everything freezes
  // while i_valid is low.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      tick       <= '0;
      data_cnt   <= '0;
      stop_cnt   <= '0;
      shreg      <= '0;
      parity_err <= 1'b0;
      frame_acc  <= 1'b0;
    end else if (i_valid) begin
      state <= state_next;
      tick  <= (state_next != state) ? '0 : tick + 1'b1;
      if (state == ST_IDLE) frame_acc <= 1'b0;
      if ((state == ST_DATA) && mid_bit) begin
        shreg    <= (shreg >> 1) | (N_DATA'(rx) << (N_DATA - 1));
        data_cnt <= (data_cnt == LAST_DATA) ? '0 : data_cnt + 1'b1;
      end
      if ((state == ST_PARITY) && mid_bit) begin
        parity_err <= (rx != expected_parity(32'(shreg), PARITY_RULE));
      end
      if ((state == ST_STOP) && mid_bit) begin
        frame_acc <= frame_acc | ~rx;
        stop_cnt  <= (stop_cnt == LAST_STOP) ? '0 : stop_cnt + 1'b1;
      end
    end
  end

  // Deliver the word and status on the last stop sample; they hold until
  // the next frame completes, even when the frame carried errors.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data         <= '0;
      o_rx_done      <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
    end else begin
      o_rx_done <= frame_done;
      if (frame_done) begin
        o_data         <= NB_DATA'(shreg);
        o_parity_error <= HAS_PARITY ? parity_err : 1'b0;
        o_frame_error  <= frame_acc | ~rx;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, counterpart of the team's uart_tx.
- Uses the same baud-tick convention: i_valid is the oversampling tick, with OVERSAMPLE ticks per bit.
- Deserialises one start bit, N_DATA data bits (LSB first), an optional parity bit and M_STOP stop bits into a parallel word.
- Flags parity and framing errors, and sits between the pad-side RX line and the UART interface / command logic.

Parameters:
- NB_DATA, 8, width of the parallel output word.
- N_DATA, 8, data bits per frame (1..NB_DATA).
- LOG2_N_DATA, 4, width of the data-bit counter (must hold N_DATA).
- PARITY_CHECK, 0, 1 = a parity bit follows the data bits.
- EVEN_ODD_PARITY, 1, 1 = expected parity is ^data; 0 = expected parity is ~^data (same rule as uart_tx).
- M_STOP, 1, number of stop bits (>=1).
- LOG2_M_STOP, 1, width of the stop-bit counter.
- OVERSAMPLE, 16, ticks per bit; power of two, >=4.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  1  asynchronous serial RX line; idle high.
- i_valid  in  1  oversampling tick; all FSM, counter and sampling activity advances only on cycles with i_valid=1.
- o_data  out  NB_DATA  last received word; bits [N_DATA-1:0] hold the data, upper bits are 0.
- o_rx_done  out  1  one-clock pulse when a frame completes.
- o_parity_error  out  1  parity status of the last frame.
- o_frame_error  out  1  1 if any stop bit of the last frame sampled 0.

Behaviour:
- Input synchroniser: 2-flop synchroniser on i_data, clocked every cycle and reset to 1. All logic below uses the synchronised value (rx).
- Reset values: o_data=0, o_rx_done=0, o_parity_error=0, o_frame_error=0, state=IDLE, all counters=0.
- Tick counter: width log2(OVERSAMPLE). It is cleared on every state transition and increments on i_valid.
- FSM states, each advancing only when i_valid=1:
  - IDLE: rx==0 -> START, clear tick counter.
  - START: when tick==OVERSAMPLE/2-1 (mid start bit), re-check rx. If rx==0 -> DATA. If rx==1 it is a glitch -> IDLE with no outputs changed.
  - DATA: when tick==OVERSAMPLE-1 (mid bit), shift rx in LSB-first and increment the data counter. After the N_DATA-th bit go to PARITY if PARITY_CHECK=1, else to STOP.
  - PARITY: at mid bit, store parity_err = (rx != expected parity over the N_DATA received bits), then go to STOP.
  - STOP: at mid bit, sample rx. Any 0 sets the frame-error accumulator. Increment the stop counter. After the M_STOP-th sample go to IDLE.
- Frame completion, on the cycle of the last stop sample:
  - o_data <= assembled word; o_parity_error <= parity_err (forced 0 when PARITY_CHECK=0); o_frame_error <= accumulator.
  - o_rx_done=1 for exactly that clock.
  - The word is delivered even if it has errors.
- Returning to IDLE at mid stop bit gives half a bit of resynchronisation margin. A start edge arriving immediately after is accepted.
- Hold behaviour: outputs hold their values between frames, and the error flags are overwritten at each frame completion.
- Latency: o_rx_done rises (N_DATA+PARITY_CHECK+M_STOP)*OVERSAMPLE + OVERSAMPLE/2 ticks after the first tick that sees rx low, plus 2 clocks of synchroniser delay.
- Gapped ticks: if i_valid is deasserted, state and counters freeze.
- Line held low (break): the frame completes with o_frame_error=1. The FSM then restarts a new frame from IDLE on the next tick because rx is still 0. This is accepted behaviour.
- Mid-frame reset: a synchronous reset mid-frame aborts the frame with no o_rx_done and returns all outputs to their reset values.

Decomposition:
- Shared uart package holds:
  - the state encoding (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP; 3 bits);
  - the default OVERSAMPLE;
  - the parity-rule definition, shared with uart_tx so both ends agree.
- One sub-module is natural: uart_rx_sync, the 2-flop synchroniser with reset value 1. Everything else stays in uart_rx.

Test Plan:
- Defaults, i_valid=1 every clock: send 0xA5 (8N1, 16 ticks/bit) -> o_rx_done pulses once 154 clocks after the falling edge (152 ticks + 2 sync clocks); o_data=0xA5; both error flags 0.
- PARITY_CHECK=1, EVEN_ODD_PARITY=1: send 0x07 with parity bit 1 -> o_parity_error=0. Repeat with parity bit 0 -> o_data=0x07, o_parity_error=1.
- M_STOP=2: send 0x3C with the second stop bit driven 0 -> o_data=0x3C, o_frame_error=1, o_rx_done pulses once.
- Glitch: drive the line low for 4 ticks, then high -> FSM returns to IDLE and o_rx_done never asserts. A following 0x5A frame is received correctly.
- i_valid every 4th clock; send back-to-back frames 0x00 and 0xFF -> two o_rx_done pulses with the correct words in order, and no pulse while i_valid=0.
- Assert i_reset during DATA of frame 0x81 -> no o_rx_done and o_data=0. The next frame 0x42 is received correctly.
